regs_wb_sched: RTL and testbench
================================

// Module: regs_wb_sched
// PURPOSE
//  Write-back scheduler and scoreboard for the 32x32 register file. Arbitrates the single
//  regfile write port between the single-cycle ALU path and the long-latency unit (LSU/muldiv),
//  and tracks registers with an outstanding long-latency write. Raises a decode stall on
//  RAW/WAW hazards against those registers. Sits between the execute/LSU stages and the regfile.
// PARAMETERS
//  STARVE_MAX  4   consecutive refused LU cycles before a forced issue bubble (1..15)
//  CNT_W       32  width of the statistics counters (WB_SCHED_STATS_EN only)
// PORTS
//  clk             in   1   clock
//  rst             in   1   reset, synchronous, active-high
//  id_issue_i      in   1   decode presents a valid instruction this cycle
//  id_issue_long_i in   1   the presented instruction is a long-latency op writing id_rd_addr_i
//  id_rs1_addr_i   in   5   decode source 1
//  id_rs2_addr_i   in   5   decode source 2
//  id_rd_addr_i    in   5   decode destination
//  stall_o         out  1   hold decode; the instruction is not issued this cycle
//  alu_wb_valid_i  in   1   ALU write-back request (no backpressure)
//  alu_wb_addr_i   in   5   ALU destination
//  alu_wb_data_i   in   32  ALU result
//  lu_wb_valid_i   in   1   LU write-back request
//  lu_wb_addr_i    in   5   LU destination
//  lu_wb_data_i    in   32  LU result
//  lu_wb_ready_o   out  1   LU write-back accepted when valid&ready
//  wr_en_o         out  1   regfile write enable
//  rd_addr_o       out  5   regfile write address
//  rd_data_o       out  32  regfile write data
//  busy_o          out  32  scoreboard; bit n = long write to xn pending (bit 0 always 0)
//  err_o           out  1   sticky: LU write-back to a register that is not busy
// BEHAVIOUR
//  - Reset: busy_o=0, err_o=0, wr_en_o=0, rd_addr_o=0, rd_data_o=0, starve count=0.
//    lu_wb_ready_o=0 and stall_o=1 while rst is high. Reset mid-operation drops any
//    pending LU write-back and clears all scoreboard bits.
//  - ALU slot: alu_wb_valid_i & alu_wb_addr_i!=0. An ALU write to x0 is dropped and does not
//    occupy the port.
//  - Arbitration, fixed ALU priority: lu_wb_ready_o = ~rst & ~ALU slot (combinational).
//  - Write port registered, 1-cycle latency: the winner's addr/data is presented on
//    rd_addr_o/rd_data_o with wr_en_o=1 in the next cycle. No winner -> wr_en_o=0 next cycle,
//    addr/data hold their previous values. An LU write to x0 is accepted but gives wr_en_o=0.
//  - Scoreboard set: id_issue_i & id_issue_long_i & ~stall_o & id_rd_addr_i!=0 sets
//    busy[rd] at the next edge.
//  - Scoreboard clear: LU accept (valid&ready) clears busy[lu_wb_addr_i] at the next edge,
//    the same edge the write is registered. The regfile same-cycle bypass covers the
//    following decode read.
//  - The same-address set and clear cannot coincide because WAW stalls. If they do, set wins.
//  - err_o sets on an LU accept with busy[lu_wb_addr_i]=0 and addr!=0. Only rst clears it.
//  - hazard = id_issue_i & ((rs1!=0 & busy[rs1]) | (rs2!=0 & busy[rs2]) | (rd!=0 & busy[rd])).
//    Uses the registered busy value, so there is no same-cycle clear bypass.
//  - Starve counter: increments each cycle with lu_wb_valid_i & ~lu_wb_ready_o, saturating at
//    STARVE_MAX. It resets to 0 on an LU accept or when lu_wb_valid_i=0.
//  - starve = (count==STARVE_MAX). The starve term inserts issue bubbles until the LU wins.
//  - stall_o = rst | hazard | starve.
// CONFIGURATION
//  WB_SCHED_STATS_EN defined: adds outputs stall_cnt_o[CNT_W] (cycles with id_issue_i&stall_o)
//  and conflict_cnt_o[CNT_W] (cycles with ALU slot & lu_wb_valid_i). Both wrap, zeroed by rst.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  - ALU valid addr=5 data=0xA5 -> next cycle wr_en_o=1, rd_addr_o=5, rd_data_o=0xA5.
//    ALU addr=0 -> wr_en_o=0.
//  - Issue long rd=7, then LU valid addr=7 data=0x1234 with no ALU -> busy_o[7]=1 until accept,
//    lu_wb_ready_o=1, then busy_o[7]=0 and wr_en_o=1, rd_addr_o=7.
//  - busy[7]=1, decode rs2=7 -> stall_o=1, no busy change.
//    Decode rs1=0 with busy[0]=0 -> no stall. WAW rd=7 -> stall_o=1.
//  - ALU and LU valid every cycle -> ALU written. After STARVE_MAX=4 refused cycles stall_o=1.
//    Once the ALU slot empties, the LU is accepted and the counter returns to 0.
//  - LU accept addr=9 with busy[9]=0 -> err_o=1 and it stays 1. Assert rst mid-LU-wait ->
//    busy_o=0, err_o=0, wr_en_o=0 next cycle.
//  - Stats build, 3 stall cycles and 2 conflict cycles -> stall_cnt_o=3, conflict_cnt_o=2.

Source files
------------

// File: rtl/regs_wb_sched_if.sv
// ----------------------------------------------------------------------------
// regs_wb_sched_if
//   Bundle of the decode, ALU write-back, LU write-back and regfile write-port
//   signals around the write-back scheduler.
//   modport slave  : the scheduler (regs_wb_sched)
//   modport master : the surrounding pipeline (decode, execute, LSU/muldiv)
//   Signals:
//     id_issue_i, id_issue_long_i, id_rs1/rs2/rd_addr_i  decode presentation
//     stall_o                                            decode hold
//     alu_wb_valid_i, alu_wb_addr_i, alu_wb_data_i       ALU write-back
//     lu_wb_valid_i, lu_wb_addr_i, lu_wb_data_i,
//     lu_wb_ready_o                                      LU write-back handshake
//     wr_en_o, rd_addr_o, rd_data_o                      regfile write port
//     busy_o                                             scoreboard
//     err_o                                              sticky LU write-back error
// ----------------------------------------------------------------------------
interface regs_wb_sched_if;
    logic        id_issue_i;
    logic        id_issue_long_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic [4:0]  id_rd_addr_i;
    logic        stall_o;

    logic        alu_wb_valid_i;
    logic [4:0]  alu_wb_addr_i;
    logic [31:0] alu_wb_data_i;

    logic        lu_wb_valid_i;
    logic [4:0]  lu_wb_addr_i;
    logic [31:0] lu_wb_data_i;
    logic        lu_wb_ready_o;

    logic        wr_en_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;

    logic [31:0] busy_o;
    logic        err_o;

    modport slave (
        input  id_issue_i, id_issue_long_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i,
        output stall_o,
        input  alu_wb_valid_i, alu_wb_addr_i, alu_wb_data_i,
        input  lu_wb_valid_i, lu_wb_addr_i, lu_wb_data_i,
        output lu_wb_ready_o,
        output wr_en_o, rd_addr_o, rd_data_o,
        output busy_o, err_o
    );

    modport master (
        output id_issue_i, id_issue_long_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i,
        input  stall_o,
        output alu_wb_valid_i, alu_wb_addr_i, alu_wb_data_i,
        output lu_wb_valid_i, lu_wb_addr_i, lu_wb_data_i,
        input  lu_wb_ready_o,
        input  wr_en_o, rd_addr_o, rd_data_o,
        input  busy_o, err_o
    );
endinterface

// File: rtl/regs_wb_sched.sv
// ----------------------------------------------------------------------------
// regs_wb_sched
//   Write-back scheduler and scoreboard for the 32x32 register file.
//   Arbitrates the single regfile write port between the single-cycle ALU
//   path (fixed priority) and the long-latency unit (LSU/muldiv), tracks
//   registers with an outstanding long-latency write and stalls decode on
//   RAW/WAW hazards against them. A starvation counter forces issue bubbles
//   when the LU has been refused STARVE_MAX cycles in a row, so the ALU slot
//   drains and the LU gets the port.
//
//   Parameters:
//     STARVE_MAX  consecutive refused LU cycles before forcing bubbles (1..15)
//     CNT_W       width of the statistics counters
//   Ports:
//     clk          clock
//     rst          synchronous, active-high reset
//     bus          regs_wb_sched_if.slave (decode, ALU/LU write-back, regfile
//                  write port, scoreboard, error flag)
//     stall_cnt_o  cycles with id_issue_i & stall_o      (stats build only)
//     conflict_cnt_o cycles with ALU slot & lu_wb_valid_i (stats build only)
//
//   Build option: define WB_SCHED_STATS_EN to add the two wrapping statistics
//   counters and their output ports. Without it the ports and counters are
//   absent and all other behaviour is identical.
// ----------------------------------------------------------------------------
module regs_wb_sched #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 32
) (
    input  logic                clk,
    input  logic                rst,
    regs_wb_sched_if.slave      bus
`ifdef WB_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0]    stall_cnt_o,
    output logic [CNT_W-1:0]    conflict_cnt_o
`endif
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [31:0] busy_q;
    logic [31:0] busy_d;
    logic        err_q;
    logic        err_d;
    logic [3:0]  starve_cnt_q;
    logic [3:0]  starve_cnt_d;

    logic        wr_en_q;
    logic        wr_en_d;
    logic [4:0]  rd_addr_q;
    logic [4:0]  rd_addr_d;
    logic [31:0] rd_data_q;
    logic [31:0] rd_data_d;

    logic        alu_slot;
    logic        lu_ready;
    logic        lu_accept;
    logic        hazard;
    logic        starve;
    logic        stall;
    logic        long_set;

    // ------------------------------------------------------------------
    // Arbitration and decode hazard (combinational)
    // ------------------------------------------------------------------

    // An ALU write to x0 is discarded and leaves the port free for the LU.
    assign alu_slot  = bus.alu_wb_valid_i && (bus.alu_wb_addr_i != 5'd0);
    assign lu_ready  = !rst && !alu_slot;
    assign lu_accept = bus.lu_wb_valid_i && lu_ready;

    // Hazard looks at the registered scoreboard only; a clear landing this
    // cycle is seen by decode one cycle later, when the regfile bypass
    // already covers the read.
    always_comb begin
        hazard = 1'b0;
        if (bus.id_issue_i) begin
            if ((bus.id_rs1_addr_i != 5'd0) && busy_q[bus.id_rs1_addr_i]) hazard = 1'b1;
            if ((bus.id_rs2_addr_i != 5'd0) && busy_q[bus.id_rs2_addr_i]) hazard = 1'b1;
            if ((bus.id_rd_addr_i  != 5'd0) && busy_q[bus.id_rd_addr_i])  hazard = 1'b1;
        end
    end

    assign starve   = (starve_cnt_q == STARVE_LIM);
    assign stall    = rst || hazard || starve;
    assign long_set = bus.id_issue_i && bus.id_issue_long_i && !stall &&
                      (bus.id_rd_addr_i != 5'd0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------

    // Write port: ALU first, then an accepted LU write. With no winner the
    // address/data hold so the regfile sees stable values.
    always_comb begin
        wr_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (alu_slot) begin
            wr_en_d   = 1'b1;
            rd_addr_d = bus.alu_wb_addr_i;
            rd_data_d = bus.alu_wb_data_i;
        end else if (lu_accept && (bus.lu_wb_addr_i != 5'd0)) begin
            // An LU write to x0 is still accepted (handshake completes) but
            // never reaches the regfile.
            wr_en_d   = 1'b1;
            rd_addr_d = bus.lu_wb_addr_i;
            rd_data_d = bus.lu_wb_data_i;
        end
    end

    // Scoreboard: clear applied before set so a coinciding set wins.
    always_comb begin
        busy_d = busy_q;
        if (lu_accept) begin
            busy_d[bus.lu_wb_addr_i] = 1'b0;
        end
        if (long_set) begin
            busy_d[bus.id_rd_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        err_d = err_q;
        if (lu_accept && (bus.lu_wb_addr_i != 5'd0) && !busy_q[bus.lu_wb_addr_i]) begin
            err_d = 1'b1;
        end
    end

    // Counts consecutive refused LU cycles; any accept or idle LU restarts it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (lu_accept || !bus.lu_wb_valid_i) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q != STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q      <= 1'b0;
            rd_addr_q    <= 5'd0;
            rd_data_q    <= 32'd0;
            busy_q       <= 32'd0;
            err_q        <= 1'b0;
            starve_cnt_q <= 4'd0;
        end else begin
            wr_en_q      <= wr_en_d;
            rd_addr_q    <= rd_addr_d;
            rd_data_q    <= rd_data_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.stall_o       = stall;
    assign bus.lu_wb_ready_o = lu_ready;
    assign bus.wr_en_o       = wr_en_q;
    assign bus.rd_addr_o     = rd_addr_q;
    assign bus.rd_data_o     = rd_data_q;
    assign bus.busy_o        = busy_q;
    assign bus.err_o         = err_q;

`ifdef WB_SCHED_STATS_EN
    // ------------------------------------------------------------------
    // Statistics (wrapping)
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] conflict_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (bus.id_issue_i && stall) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (alu_slot && bus.lu_wb_valid_i) begin
                conflict_cnt_q <= conflict_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o    = stall_cnt_q;
    assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_regs_wb_sched.sv
// ----------------------------------------------------------------------------
// tb_regs_wb_sched
//   Directed testbench for regs_wb_sched (STARVE_MAX = 4). Inputs change #1
//   after the rising edge; combinational outputs are sampled #1 later and
//   registered outputs #1 after the following rising edge.
//   Define WB_SCHED_STATS_EN to also exercise the statistics counters.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regs_wb_sched;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    regs_wb_sched_if bus ();

`ifdef WB_SCHED_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] conflict_cnt;
`endif

    regs_wb_sched #(
        .STARVE_MAX (4),
        .CNT_W      (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus)
`ifdef WB_SCHED_STATS_EN
        ,
        .stall_cnt_o    (stall_cnt),
        .conflict_cnt_o (conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_issue_i      = 1'b0;
        bus.id_issue_long_i = 1'b0;
        bus.id_rs1_addr_i   = 5'd0;
        bus.id_rs2_addr_i   = 5'd0;
        bus.id_rd_addr_i    = 5'd0;
        bus.alu_wb_valid_i  = 1'b0;
        bus.alu_wb_addr_i   = 5'd0;
        bus.alu_wb_data_i   = 32'd0;
        bus.lu_wb_valid_i   = 1'b0;
        bus.lu_wb_addr_i    = 5'd0;
        bus.lu_wb_data_i    = 32'd0;
    endtask

    task automatic issue(input logic is_long, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd);
        bus.id_issue_i      = 1'b1;
        bus.id_issue_long_i = is_long;
        bus.id_rs1_addr_i   = rs1;
        bus.id_rs2_addr_i   = rs2;
        bus.id_rd_addr_i    = rd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.lu_wb_valid_i = 1'b1;
        bus.lu_wb_addr_i  = 5'd3;
        tick();
        tick();
        #1;
        tests++; if (bus.stall_o !== 1'b1) begin fails++; $display("FAIL rst_stall got=%b exp=1", bus.stall_o); end
        tests++; if (bus.lu_wb_ready_o !== 1'b0) begin fails++; $display("FAIL rst_ready got=%b exp=0", bus.lu_wb_ready_o); end
        tests++; if (bus.wr_en_o !== 1'b0) begin fails++; $display("FAIL rst_wr_en got=%b exp=0", bus.wr_en_o); end
        tests++; if (bus.rd_addr_o !== 5'd0 || bus.rd_data_o !== 32'd0) begin fails++; $display("FAIL rst_port got=%0d/%h exp=0/0", bus.rd_addr_o, bus.rd_data_o); end
        tests++; if (bus.busy_o !== 32'd0 || bus.err_o !== 1'b0) begin fails++; $display("FAIL rst_busy_err got=%h/%b exp=0/0", bus.busy_o, bus.err_o); end
        rst = 1'b0;
        idle();
        #1;
        tests++; if (bus.stall_o !== 1'b0 || bus.lu_wb_ready_o !== 1'b1) begin fails++; $display("FAIL post_rst got stall=%b ready=%b exp 0/1", bus.stall_o, bus.lu_wb_ready_o); end
        tick();
    endtask

    task automatic test_alu();
        bus.alu_wb_valid_i = 1'b1;
        bus.alu_wb_addr_i  = 5'd5;
        bus.alu_wb_data_i  = 32'hA5;
        tick();
        tests++; if (bus.wr_en_o !== 1'b1 || bus.rd_addr_o !== 5'd5 || bus.rd_data_o !== 32'hA5) begin fails++; $display("FAIL alu_write got=%b/%0d/%h exp=1/5/a5", bus.wr_en_o, bus.rd_addr_o, bus.rd_data_o); end
        bus.alu_wb_addr_i  = 5'd0;
        bus.alu_wb_data_i  = 32'hFF;
        #1;
        tests++; if (bus.lu_wb_ready_o !== 1'b1) begin fails++; $display("FAIL alu_x0_ready got=%b exp=1", bus.lu_wb_ready_o); end
        tick();
        tests++; if (bus.wr_en_o !== 1'b0 || bus.rd_addr_o !== 5'd5 || bus.rd_data_o !== 32'hA5) begin fails++; $display("FAIL alu_x0 got=%b/%0d/%h exp=0/5/a5", bus.wr_en_o, bus.rd_addr_o, bus.rd_data_o); end
        idle();
    endtask

    task automatic test_long();
        issue(1'b1, 5'd0, 5'd0, 5'd7);
        #1;
        tests++; if (bus.stall_o !== 1'b0) begin fails++; $display("FAIL long_issue_stall got=%b exp=0", bus.stall_o); end
        tick();
        idle();
        bus.lu_wb_valid_i = 1'b1;
        bus.lu_wb_addr_i  = 5'd7;
        bus.lu_wb_data_i  = 32'h1234;
        #1;
        tests++; if (bus.busy_o !== 32'h0000_0080) begin fails++; $display("FAIL long_busy_set got=%h exp=00000080", bus.busy_o); end
        tests++; if (bus.lu_wb_ready_o !== 1'b1) begin fails++; $display("FAIL long_ready got=%b exp=1", bus.lu_wb_ready_o); end
        tick();
        idle();
        tests++; if (bus.busy_o !== 32'd0) begin fails++; $display("FAIL long_busy_clr got=%h exp=0", bus.busy_o); end
        tests++; if (bus.wr_en_o !== 1'b1 || bus.rd_addr_o !== 5'd7 || bus.rd_data_o !== 32'h1234) begin fails++; $display("FAIL long_write got=%b/%0d/%h exp=1/7/1234", bus.wr_en_o, bus.rd_addr_o, bus.rd_data_o); end
        tests++; if (bus.err_o !== 1'b0) begin fails++; $display("FAIL long_err got=%b exp=0", bus.err_o); end
    endtask

    task automatic test_hazard();
        issue(1'b1, 5'd0, 5'd0, 5'd7);
        tick();
        issue(1'b0, 5'd1, 5'd7, 5'd2);
        #1;
        tests++; if (bus.stall_o !== 1'b1) begin fails++; $display("FAIL raw_rs2_stall got=%b exp=1", bus.stall_o); end
        tick();
        tests++; if (bus.busy_o !== 32'h0000_0080) begin fails++; $display("FAIL raw_busy_hold got=%h exp=00000080", bus.busy_o); end
        issue(1'b0, 5'd0, 5'd0, 5'd3);
        #1;
        tests++; if (bus.stall_o !== 1'b0) begin fails++; $display("FAIL rs1_x0_stall got=%b exp=0", bus.stall_o); end
        issue(1'b1, 5'd0, 5'd0, 5'd7);
        #1;
        tests++; if (bus.stall_o !== 1'b1) begin fails++; $display("FAIL waw_stall got=%b exp=1", bus.stall_o); end
        tick();
        tests++; if (bus.busy_o !== 32'h0000_0080) begin fails++; $display("FAIL waw_busy_hold got=%h exp=00000080", bus.busy_o); end
        idle();
        bus.lu_wb_valid_i = 1'b1;
        bus.lu_wb_addr_i  = 5'd7;
        bus.lu_wb_data_i  = 32'h77;
        tick();
        idle();
        tests++; if (bus.busy_o !== 32'd0) begin fails++; $display("FAIL hazard_cleanup got=%h exp=0", bus.busy_o); end
    endtask

    task automatic test_starve();
        issue(1'b1, 5'd0, 5'd0, 5'd4);
        tick();
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 5'd0, 5'd0, 5'd0);
            bus.alu_wb_valid_i = 1'b1;
            bus.alu_wb_addr_i  = 5'd1;
            bus.alu_wb_data_i  = 32'(i + 16);
            bus.lu_wb_valid_i  = 1'b1;
            bus.lu_wb_addr_i   = 5'd4;
            bus.lu_wb_data_i   = 32'h44;
            #1;
            tests++; if (bus.lu_wb_ready_o !== 1'b0 || bus.stall_o !== 1'b0) begin fails++; $display("FAIL starve_pre%0d got ready=%b stall=%b exp 0/0", i, bus.lu_wb_ready_o, bus.stall_o); end
            tick();
            tests++; if (bus.wr_en_o !== 1'b1 || bus.rd_addr_o !== 5'd1 || bus.rd_data_o !== 32'(i + 16)) begin fails++; $display("FAIL starve_alu%0d got=%b/%0d/%h exp=1/1/%h", i, bus.wr_en_o, bus.rd_addr_o, bus.rd_data_o, i + 16); end
        end
        #1;
        tests++; if (bus.stall_o !== 1'b1) begin fails++; $display("FAIL starve_stall got=%b exp=1", bus.stall_o); end
        bus.alu_wb_valid_i = 1'b0;
        #1;
        tests++; if (bus.lu_wb_ready_o !== 1'b1 || bus.stall_o !== 1'b1) begin fails++; $display("FAIL starve_drain got ready=%b stall=%b exp 1/1", bus.lu_wb_ready_o, bus.stall_o); end
        tick();
        tests++; if (bus.wr_en_o !== 1'b1 || bus.rd_addr_o !== 5'd4 || bus.rd_data_o !== 32'h44 || bus.busy_o !== 32'd0) begin fails++; $display("FAIL starve_lu_win got=%b/%0d/%h busy=%h exp=1/4/44 busy=0", bus.wr_en_o, bus.rd_addr_o, bus.rd_data_o, bus.busy_o); end
        bus.alu_wb_valid_i = 1'b1;
        bus.alu_wb_addr_i  = 5'd1;
        #1;
        tests++; if (bus.stall_o !== 1'b0) begin fails++; $display("FAIL starve_cnt_reset got stall=%b exp=0", bus.stall_o); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_err();
        bus.lu_wb_valid_i = 1'b1;
        bus.lu_wb_addr_i  = 5'd0;
        bus.lu_wb_data_i  = 32'h55;
        #1;
        tests++; if (bus.lu_wb_ready_o !== 1'b1) begin fails++; $display("FAIL lu_x0_ready got=%b exp=1", bus.lu_wb_ready_o); end
        tick();
        tests++; if (bus.wr_en_o !== 1'b0 || bus.err_o !== 1'b0 || bus.rd_addr_o !== 5'd1) begin fails++; $display("FAIL lu_x0 got wr=%b err=%b addr=%0d exp 0/0/1", bus.wr_en_o, bus.err_o, bus.rd_addr_o); end
        bus.lu_wb_addr_i = 5'd9;
        bus.lu_wb_data_i = 32'h99;
        tick();
        idle();
        tests++; if (bus.err_o !== 1'b1) begin fails++; $display("FAIL err_set got=%b exp=1", bus.err_o); end
        tick();
        tick();
        tests++; if (bus.err_o !== 1'b1) begin fails++; $display("FAIL err_sticky got=%b exp=1", bus.err_o); end
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 5'd0, 5'd0, 5'd12);
        tick();
        idle();
        bus.alu_wb_valid_i = 1'b1;
        bus.alu_wb_addr_i  = 5'd2;
        bus.alu_wb_data_i  = 32'h22;
        bus.lu_wb_valid_i  = 1'b1;
        bus.lu_wb_addr_i   = 5'd12;
        bus.lu_wb_data_i   = 32'hC0;
        tick();
        tests++; if (bus.busy_o !== 32'h0000_1000 || bus.wr_en_o !== 1'b1 || bus.rd_addr_o !== 5'd2) begin fails++; $display("FAIL mid_pre got busy=%h wr=%b addr=%0d exp 00001000/1/2", bus.busy_o, bus.wr_en_o, bus.rd_addr_o); end
        rst = 1'b1;
        tick();
        tests++; if (bus.busy_o !== 32'd0 || bus.err_o !== 1'b0 || bus.wr_en_o !== 1'b0) begin fails++; $display("FAIL mid_rst got busy=%h err=%b wr=%b exp 0/0/0", bus.busy_o, bus.err_o, bus.wr_en_o); end
        rst = 1'b0;
        idle();
        tick();
        tests++; if (bus.busy_o !== 32'd0 || bus.wr_en_o !== 1'b0) begin fails++; $display("FAIL mid_after got busy=%h wr=%b exp 0/0", bus.busy_o, bus.wr_en_o); end
    endtask

`ifdef WB_SCHED_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        #1;
        tests++; if (stall_cnt !== 32'd0 || conflict_cnt !== 32'd0) begin fails++; $display("FAIL stats_rst got=%0d/%0d exp=0/0", stall_cnt, conflict_cnt); end
        issue(1'b1, 5'd0, 5'd0, 5'd10);
        tick();
        issue(1'b0, 5'd10, 5'd0, 5'd0);
        tick();
        tick();
        tick();
        idle();
        bus.alu_wb_valid_i = 1'b1;
        bus.alu_wb_addr_i  = 5'd3;
        bus.lu_wb_valid_i  = 1'b1;
        bus.lu_wb_addr_i   = 5'd10;
        tick();
        tick();
        idle();
        tick();
        tests++; if (stall_cnt !== 32'd3) begin fails++; $display("FAIL stats_stall got=%0d exp=3", stall_cnt); end
        tests++; if (conflict_cnt !== 32'd2) begin fails++; $display("FAIL stats_conflict got=%0d exp=2", conflict_cnt); end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        idle();
        test_reset();
        test_alu();
        test_long();
        test_hazard();
        test_starve();
        test_err();
        test_reset_mid();
`ifdef WB_SCHED_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
